ram_dp_mem: RTL and testbench

//  Parametrised simple dual-port synchronous RAM: one write port, one read port, one clock.

---
 rtl/ram_dp_mem_if.sv | 44 ++++
 rtl/ram_dp_mem.sv | 196 +++++++++++++++++++
 tb/tb_ram_dp_mem.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_mem_if
// Description : Bus bundle for ram_dp_mem: write port, read port, init
//               control and status. The master modport belongs to the wr/rd
//               agents; the slave modport belongs to the RAM.
//               Signals:
//                 wr_enb/wr_addr/wr_data/wr_be  write request, byte enables
//                 rd_enb/rd_addr                read request
//                 rd_data/rd_valid              read response
//                 init_req/init_busy            initialisation control/status
//                 collision/addr_err            per-request status pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_dp_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_req;
  logic                  init_busy;
  logic                  collision;
  logic                  addr_err;

  modport master (
    output wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr, init_req,
    input  rd_data, rd_valid, init_busy, collision, addr_err
  );

  modport slave (
    input  wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr, init_req,
    output rd_data, rd_valid, init_busy, collision, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/ram_dp_mem.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_mem
// Description : Parametrised simple dual-port synchronous RAM (one write
//               port, one read port, one clock) with byte enables, 1- or
//               2-cycle read latency, selectable read-during-write mode, a
//               hardware init FSM and out-of-range address detection.
// Ports       : clk        clock, rising edge
//               rst_n      asynchronous active-low reset
//               bus.slave  wr_enb/wr_addr/wr_data/wr_be   write port
//                          rd_enb/rd_addr                 read port
//                          rd_data/rd_valid               read response
//                          init_req (in) / init_busy (out)
//                          collision, addr_err            status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_mem #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 16,
  parameter int                    RD_LATENCY = 1,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_dp_mem_if.slave bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W    = $clog2(DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]    c_cnt_last = CNT_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage-1 read pipeline (also carries the address-error flag so that
  // write and read errors land on the same cycle and merge into one pulse).
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
  logic                  s1_coll_q,  s1_coll_d;
  logic                  s1_err_q,   s1_err_d;

  logic                  w_run;
  logic                  w_wr_acc, w_wr_oor, w_wr_do;
  logic                  w_rd_acc, w_rd_oor, w_rd_in;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  assign w_run    = (state_q == ST_RUN);
  assign w_wr_acc = w_run & bus.wr_enb;
  assign w_rd_acc = w_run & bus.rd_enb;
  assign w_wr_oor = !({1'b0, bus.wr_addr} < c_depth);
  assign w_rd_oor = !({1'b0, bus.rd_addr} < c_depth);
  assign w_wr_do  = w_wr_acc & !w_wr_oor;
  assign w_rd_in  = w_rd_acc & !w_rd_oor;

  // Only a write that really lands in the array can collide with a read.
  assign w_collide = w_rd_in & w_wr_do & (bus.rd_addr == bus.wr_addr);

  // --------------------------------------------------------------------------
  // Init / run FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == c_cnt_last) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.init_req) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  assign bus.init_busy = (state_q == ST_INIT);

  // --------------------------------------------------------------------------
  // Memory array: no reset, it is rewritten by the init FSM after reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (w_wr_do) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (bus.wr_be[b]) begin
          mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word: array contents are the pre-write word because the write is a
  // non-blocking update. Write-first mode overlays the enabled write bytes.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in) begin
      w_rd_word = mem[bus.rd_addr];
      if ((RDW_MODE == 1) && w_collide) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (bus.wr_be[b]) begin
            w_rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline stage 1
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = w_rd_acc;
    s1_data_d  = w_rd_acc ? w_rd_word : s1_data_q;
    s1_coll_d  = w_collide;
    s1_err_d   = (w_rd_acc & w_rd_oor) | (w_wr_acc & w_wr_oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_coll_q  <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_coll_q  <= s1_coll_d;
      s1_err_q   <= s1_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional second stage. The error flag rides with the read so that a read
  // error lines up with its rd_valid; write errors follow the same delay.
  // --------------------------------------------------------------------------
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;
      logic                  s2_coll_q,  s2_coll_d;
      logic                  s2_err_q,   s2_err_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        s2_coll_d  = s1_coll_q;
        s2_err_d   = s1_err_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
          s2_coll_q  <= 1'b0;
          s2_err_q   <= 1'b0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
          s2_coll_q  <= s2_coll_d;
          s2_err_q   <= s2_err_d;
        end
      end

      assign bus.rd_valid  = s2_valid_q;
      assign bus.rd_data   = s2_data_q;
      assign bus.collision = s2_coll_q;
      assign bus.addr_err  = s2_err_q;
    end else begin : g_lat1
      assign bus.rd_valid  = s1_valid_q;
      assign bus.rd_data   = s1_data_q;
      assign bus.collision = s1_coll_q;
      assign bus.addr_err  = s1_err_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dp_mem
// Description : Self-checking bench for ram_dp_mem. Instance A: 8-bit,
//               DEPTH 16, latency 1, read-first, init 8'hA5. Instance B:
//               16-bit, DEPTH 12, latency 2, write-first, init 16'h0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_mem;

  logic clk;
  logic rst_n;

  ram_dp_mem_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) ia ();
  ram_dp_mem_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) ib ();

  ram_dp_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1),
    .RDW_MODE(0), .INIT_VALUE(8'hA5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );

  ram_dp_mem #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2),
    .RDW_MODE(1), .INIT_VALUE(16'h0000)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [15:0] ed;
    logic        ec;
    logic        ee;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  function automatic vec_t mk(input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic [1:0] be,
                              input logic re, input logic [3:0] ra,
                              input logic ev, input logic [15:0] ed,
                              input logic ec, input logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    ia.wr_enb  = v.we;
    ia.wr_addr = v.wa;
    ia.wr_data = v.wd[7:0];
    ia.wr_be   = v.be[0:0];
    ia.rd_enb  = v.re;
    ia.rd_addr = v.ra;
  endtask

  task automatic drive_b(input vec_t v);
    ib.wr_enb  = v.we;
    ib.wr_addr = v.wa;
    ib.wr_data = v.wd;
    ib.wr_be   = v.be;
    ib.rd_enb  = v.re;
    ib.rd_addr = v.ra;
  endtask

  task automatic check_a(input string nm, input vec_t v);
    chk({nm, ".valid"}, {31'd0, ia.rd_valid},  {31'd0, v.ev});
    chk({nm, ".data"},  {24'd0, ia.rd_data},   {24'd0, v.ed[7:0]});
    chk({nm, ".coll"},  {31'd0, ia.collision}, {31'd0, v.ec});
    chk({nm, ".err"},   {31'd0, ia.addr_err},  {31'd0, v.ee});
  endtask

  task automatic check_b(input string nm, input vec_t v);
    chk({nm, ".valid"}, {31'd0, ib.rd_valid},  {31'd0, v.ev});
    chk({nm, ".data"},  {16'd0, ib.rd_data},   {16'd0, v.ed});
    chk({nm, ".coll"},  {31'd0, ib.collision}, {31'd0, v.ec});
    chk({nm, ".err"},   {31'd0, ib.addr_err},  {31'd0, v.ee});
  endtask

  // Counts edges until each instance drops init_busy; also notes any
  // rd_valid from B while waiting.
  task automatic wait_init(input string tag, input int exp_a, input int exp_b);
    int na = 0;
    int nb = 0;
    logic b_valid_seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ib.rd_valid) b_valid_seen = 1'b1;
      if (na == 0 && !ia.init_busy) na = n;
      if (nb == 0 && !ib.init_busy) nb = n;
      if (na != 0 && nb != 0) break;
    end
    chk({tag, ".a_init_edges"}, na, exp_a);
    chk({tag, ".b_init_edges"}, nb, exp_b);
    chk({tag, ".b_no_valid"}, {31'd0, b_valid_seen}, 32'd0);
  endtask

  vec_t idle_v;
  vec_t a_tab [11];
  vec_t b_tab [22];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    idle_v = mk(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0);

    // A (latency 1): expectations are the outputs right after the row's edge.
    a_tab[0]  = mk(1, 4'd3, 16'h3C, 2'b01, 0, 4'd0, 0, 16'hA5, 0, 0);
    a_tab[1]  = mk(0, 4'd0, 16'h00, 2'b00, 1, 4'd3, 1, 16'h3C, 0, 0);
    a_tab[2]  = mk(1, 4'd7, 16'h11, 2'b01, 0, 4'd0, 0, 16'h3C, 0, 0);
    a_tab[3]  = mk(1, 4'd7, 16'h22, 2'b01, 1, 4'd7, 1, 16'h11, 1, 0);
    a_tab[4]  = mk(0, 4'd0, 16'h00, 2'b00, 1, 4'd7, 1, 16'h22, 0, 0);
    a_tab[5]  = mk(1, 4'd5, 16'h99, 2'b00, 0, 4'd0, 0, 16'h22, 0, 0);
    a_tab[6]  = mk(0, 4'd0, 16'h00, 2'b00, 1, 4'd5, 1, 16'hA5, 0, 0);
    a_tab[7]  = mk(1, 4'd2, 16'h55, 2'b01, 1, 4'd3, 1, 16'h3C, 0, 0);
    a_tab[8]  = mk(0, 4'd0, 16'h00, 2'b00, 1, 4'd2, 1, 16'h55, 0, 0);
    a_tab[9]  = mk(0, 4'd0, 16'h00, 2'b00, 1, 4'd0, 1, 16'hA5, 0, 0);
    a_tab[10] = mk(0, 4'd0, 16'h00, 2'b00, 0, 4'd0, 0, 16'hA5, 0, 0);

    // B (latency 2): outputs after row N's edge reflect the request of row N-1.
    b_tab[0]  = mk(1, 4'd5,  16'h1234, 2'b11, 0, 4'd0,  0, 16'h0000, 0, 0);
    b_tab[1]  = mk(1, 4'd5,  16'hABCD, 2'b10, 0, 4'd0,  0, 16'h0000, 0, 0);
    b_tab[2]  = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd5,  0, 16'h0000, 0, 0);
    b_tab[3]  = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  1, 16'hAB34, 0, 0);
    b_tab[4]  = mk(1, 4'd3,  16'h003C, 2'b01, 0, 4'd0,  0, 16'hAB34, 0, 0);
    b_tab[5]  = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd3,  0, 16'hAB34, 0, 0);
    b_tab[6]  = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  1, 16'h003C, 0, 0);
    b_tab[7]  = mk(1, 4'd7,  16'h3311, 2'b11, 0, 4'd0,  0, 16'h003C, 0, 0);
    b_tab[8]  = mk(1, 4'd7,  16'h5522, 2'b01, 1, 4'd7,  0, 16'h003C, 0, 0);
    b_tab[9]  = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd7,  1, 16'h3322, 1, 0);
    b_tab[10] = mk(1, 4'd14, 16'hFFFF, 2'b11, 0, 4'd0,  1, 16'h3322, 0, 0);
    b_tab[11] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd14, 0, 16'h3322, 0, 1);
    b_tab[12] = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  1, 16'h0000, 0, 1);
    b_tab[13] = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  0, 16'h0000, 0, 0);
    b_tab[14] = mk(1, 4'd11, 16'hBEEF, 2'b11, 0, 4'd0,  0, 16'h0000, 0, 0);
    b_tab[15] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd11, 0, 16'h0000, 0, 0);
    b_tab[16] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd12, 1, 16'hBEEF, 0, 0);
    b_tab[17] = mk(1, 4'd12, 16'h0101, 2'b11, 1, 4'd13, 1, 16'h0000, 0, 1);
    b_tab[18] = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  1, 16'h0000, 0, 1);
    b_tab[19] = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  0, 16'h0000, 0, 0);
    b_tab[20] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd2,  0, 16'h0000, 0, 0);
    b_tab[21] = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  1, 16'h0000, 0, 0);

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive_a(idle_v); drive_b(idle_v);
    ia.init_req = 1'b0; ib.init_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    v = mk(0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 0, 16'h0, 0, 0);
    check_a("rst_a", v);
    check_b("rst_b", v);
    chk("rst_a.busy", {31'd0, ia.init_busy}, 32'd1);
    chk("rst_b.busy", {31'd0, ib.init_busy}, 32'd1);

    rst_n = 1'b1;
    wait_init("por", 16, 12);

    // ---------------- A: init contents sweep ----------------
    for (int i = 0; i < 16; i++) begin
      v = mk(0, 4'd0, 16'h0, 2'b00, 1, 4'(i), 1, 16'hA5, 0, 0);
      drive_a(v);
      @(posedge clk); #1;
      check_a($sformatf("sweep_a%0d", i), v);
    end

    // ---------------- A: table ----------------
    for (int i = 0; i < 11; i++) begin
      drive_a(a_tab[i]);
      @(posedge clk); #1;
      check_a($sformatf("tab_a%0d", i), a_tab[i]);
    end
    drive_a(idle_v);

    // ---------------- B: table ----------------
    for (int i = 0; i < 22; i++) begin
      drive_b(b_tab[i]);
      @(posedge clk); #1;
      check_b($sformatf("tab_b%0d", i), b_tab[i]);
    end
    drive_b(idle_v);

    // ---------------- A: init_req in RUN with a concurrent read ----------------
    ia.init_req = 1'b1; ia.rd_enb = 1'b1; ia.rd_addr = 4'd2;
    @(posedge clk); #1;
    ia.init_req = 1'b0;
    chk("ireq.valid", {31'd0, ia.rd_valid}, 32'd1);
    chk("ireq.data",  {24'd0, ia.rd_data},  32'h55);
    chk("ireq.busy",  {31'd0, ia.init_busy}, 32'd1);
    begin
      int na = 0;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (n == 1) chk("ireq.rd_ignored", {31'd0, ia.rd_valid}, 32'd0);
        ia.rd_enb = 1'b0;
        if (!ia.init_busy) begin
          na = n;
          break;
        end
      end
      chk("ireq.init_edges", na, 16);
    end
    v = mk(0, 4'd0, 16'h0, 2'b00, 1, 4'd2, 1, 16'hA5, 0, 0);
    drive_a(v);
    @(posedge clk); #1;
    check_a("ireq_reinit", v);
    drive_a(idle_v);

    // ---------------- reset mid-init and with B read outstanding ----------------
    ia.init_req = 1'b1;
    @(posedge clk); #1;
    ia.init_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    ib.rd_enb = 1'b1; ib.rd_addr = 4'd5;
    @(posedge clk); #1;
    ib.rd_enb = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst.b_valid0", {31'd0, ib.rd_valid}, 32'd0);
    chk("mrst.b_data0",  {16'd0, ib.rd_data},  32'd0);
    chk("mrst.a_busy",   {31'd0, ia.init_busy}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst.b_valid1", {31'd0, ib.rd_valid}, 32'd0);
    rst_n = 1'b1;
    wait_init("mrst", 16, 12);

    v = mk(0, 4'd0, 16'h0, 2'b00, 1, 4'd3, 1, 16'hA5, 0, 0);
    drive_a(v);
    @(posedge clk); #1;
    check_a("post_rst_a", v);
    drive_a(idle_v);

    ib.rd_enb = 1'b1; ib.rd_addr = 4'd5;
    @(posedge clk); #1;
    ib.rd_enb = 1'b0;
    chk("post_rst_b.lat", {31'd0, ib.rd_valid}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_b.valid", {31'd0, ib.rd_valid}, 32'd1);
    chk("post_rst_b.data",  {16'd0, ib.rd_data},  32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
